// File: rtl/i2c_master_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_master_ctrl
//   I2C bus master for single-byte register transfers.
//   Frame: START, slave id (8), R/W (1 = read), ack, mem address (8), ack,
//   one data byte (written by master or read from slave), ack/nack, STOP.
//   All fields MSB first. SCL is generated from clk; SDA is open-drain.
//
// Parameters
//   CLK_DIV       clk cycles per SCL quarter period (>= 1); SCL period = 4*CLK_DIV
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high
//   cmd_valid     request strobe, accepted only while idle
//   cmd_read      1 = read, 0 = write
//   cmd_slave_id  slave id byte
//   cmd_addr      slave memory address
//   cmd_wdata     write data
//   busy          high from the cycle after accept until done
//   done          one-clk pulse at transaction end (ok or error)
//   rdata         read byte, valid with done & !error, held until next accept
//   error         set with done on any NACK, cleared on next accept
//   scl_o         SCL level, push-pull
//   sda_oe        1 = pull SDA low, 0 = release
//   sda_i         sampled SDA bus value
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for cmd_valid, bus idle (SCL high, SDA released)
//   S_START    | START condition bit
//   S_SLV_ID   | shifting out slave id, 8 bits
//   S_RW       | R/W bit
//   S_ACK_SEL  | slave ack of id/RW
//   S_MEM_ADDR | shifting out memory address, 8 bits
//   S_ACK_ADDR | slave ack of address
//   S_WR_DATA  | shifting out write data, 8 bits
//   S_ACK_W    | slave ack of write data
//   S_RD_DATA  | shifting in read data, 8 bits
//   S_ACK_R    | master NACK of the single read byte
//   S_STOP     | STOP condition bit
//   S_FINISH   | one clk to raise done and drop busy
// ----------------------------------------------------------------------------
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_read,
  input  logic [7:0] cmd_slave_id,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       error,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SLV_ID,
    S_RW,
    S_ACK_SEL,
    S_MEM_ADDR,
    S_ACK_ADDR,
    S_WR_DATA,
    S_ACK_W,
    S_RD_DATA,
    S_ACK_R,
    S_STOP,
    S_FINISH
  } state_t;

  state_t        state;
  logic [QW-1:0] qdiv;
  logic [1:0]    quarter;
  logic [3:0]    bit_cnt;
  logic          read_q;
  logic [7:0]    id_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rx_shift;
  logic          sda_smp;

  logic          q_end;
  logic          is_ack;
  state_t        nxt_state;
  logic [3:0]    nxt_bit;
  logic          nxt_pull;

  // Successor of a bit-timed state, evaluated at the last clk of the bit.
  // nack is the SDA level sampled in Q2 of the current bit.
  function automatic state_t next_state_f(input state_t s, input logic [3:0] b,
                                          input logic nack, input logic rd);
    next_state_f = S_IDLE;
    case (s)
      S_START:    next_state_f = S_SLV_ID;
      S_SLV_ID:   next_state_f = (b == 4'd7) ? S_RW : S_SLV_ID;
      S_RW:       next_state_f = S_ACK_SEL;
      S_ACK_SEL:  next_state_f = nack ? S_STOP : S_MEM_ADDR;
      S_MEM_ADDR: next_state_f = (b == 4'd7) ? S_ACK_ADDR : S_MEM_ADDR;
      S_ACK_ADDR: next_state_f = nack ? S_STOP : (rd ? S_RD_DATA : S_WR_DATA);
      S_WR_DATA:  next_state_f = (b == 4'd7) ? S_ACK_W : S_WR_DATA;
      S_ACK_W:    next_state_f = S_STOP;
      S_RD_DATA:  next_state_f = (b == 4'd7) ? S_ACK_R : S_RD_DATA;
      S_ACK_R:    next_state_f = S_STOP;
      S_STOP:     next_state_f = S_FINISH;
      default:    next_state_f = S_IDLE;
    endcase
  endfunction

  // SDA drive applied on entry to Q0 of a bit. A 0 data bit pulls the line;
  // ack, read-data and master-NACK bits release it. STOP starts with SDA low.
  function automatic logic q0_pull_f(input state_t s, input logic [2:0] b,
                                     input logic rd, input logic [7:0] id,
                                     input logic [7:0] addr, input logic [7:0] wd);
    q0_pull_f = 1'b0;
    case (s)
      S_SLV_ID:   q0_pull_f = ~id[3'd7 - b];
      S_RW:       q0_pull_f = ~rd;
      S_MEM_ADDR: q0_pull_f = ~addr[3'd7 - b];
      S_WR_DATA:  q0_pull_f = ~wd[3'd7 - b];
      S_STOP:     q0_pull_f = 1'b1;
      default:    q0_pull_f = 1'b0;
    endcase
  endfunction

  assign q_end     = (qdiv == Q_LAST);
  assign is_ack    = (state == S_ACK_SEL) || (state == S_ACK_ADDR) || (state == S_ACK_W);
  assign nxt_state = next_state_f(state, bit_cnt, sda_smp, read_q);
  assign nxt_bit   = (nxt_state == state) ? bit_cnt + 4'd1 : 4'd0;
  assign nxt_pull  = q0_pull_f(nxt_state, nxt_bit[2:0], read_q, id_q, addr_q, wdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rdata    <= 8'h00;
      scl_o    <= 1'b1;
      sda_oe   <= 1'b0;
      qdiv     <= '0;
      quarter  <= 2'd0;
      bit_cnt  <= 4'd0;
      read_q   <= 1'b0;
      id_q     <= 8'h00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rx_shift <= 8'h00;
      sda_smp  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            read_q  <= cmd_read;
            id_q    <= cmd_slave_id;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            busy    <= 1'b1;
            error   <= 1'b0;
            state   <= S_START;
            qdiv    <= '0;
            quarter <= 2'd0;
            bit_cnt <= 4'd0;
            // START Q0/Q1 look like an idle bus
            scl_o   <= 1'b1;
            sda_oe  <= 1'b0;
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          if (read_q && !error) rdata <= rx_shift;
          state <= S_IDLE;
        end

        default: begin
          if (q_end) begin
            qdiv    <= '0;
            quarter <= quarter + 2'd1;

            // single sample per bit, at the last clk of Q2 (SCL high and settled)
            if (quarter == 2'd2) begin
              sda_smp <= sda_i;
              if (state == S_RD_DATA) rx_shift <= {rx_shift[6:0], sda_i};
            end

            if (quarter == 2'd3) begin
              if (is_ack && sda_smp) error <= 1'b1;
              state   <= nxt_state;
              bit_cnt <= nxt_bit;
              scl_o   <= (nxt_state == S_FINISH);
              sda_oe  <= nxt_pull;
            end else begin
              // entering quarter+1 within the same bit
              case (state)
                S_START: begin
                  scl_o <= (quarter != 2'd2);
                  if (quarter == 2'd1) sda_oe <= 1'b1;
                end
                S_STOP: begin
                  scl_o <= 1'b1;
                  if (quarter == 2'd1) sda_oe <= 1'b0;
                end
                default: scl_o <= (quarter != 2'd0);
              endcase
            end
          end else begin
            qdiv <= qdiv + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_master_ctrl
//   Two masters (CLK_DIV=4 and CLK_DIV=1) share one wired-AND bus with a
//   behavioural slave that answers id 8'h5A from its own memory. Expected
//   bit stream, latency, error and rdata are derived from the frame rules.
// ----------------------------------------------------------------------------
module tb_i2c_master_ctrl;

  localparam logic [7:0] SLV_ID = 8'h5A;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_read;
  logic [7:0] cmd_slave_id;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       fast;

  logic       busy_a, done_a, error_a, scl_a, oe_a;
  logic [7:0] rdata_a;
  logic       busy_b, done_b, error_b, scl_b, oe_b;
  logic [7:0] rdata_b;

  logic       s_pull;
  wire        scl_bus = scl_a & scl_b;
  wire        sda_bus = ~(oe_a | oe_b | s_pull);

  wire        o_busy  = fast ? busy_b  : busy_a;
  wire        o_done  = fast ? done_b  : done_a;
  wire        o_error = fast ? error_b : error_a;
  wire        o_scl   = fast ? scl_b   : scl_a;
  wire        o_oe    = fast ? oe_b    : oe_a;
  wire  [7:0] o_rdata = fast ? rdata_b : rdata_a;

  i2c_master_ctrl #(.CLK_DIV(4)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid & ~fast), .cmd_read(cmd_read),
    .cmd_slave_id(cmd_slave_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .error(error_a),
    .scl_o(scl_a), .sda_oe(oe_a), .sda_i(sda_bus)
  );

  i2c_master_ctrl #(.CLK_DIV(1)) u_dut_fast (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid & fast), .cmd_read(cmd_read),
    .cmd_slave_id(cmd_slave_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .error(error_b),
    .scl_o(scl_b), .sda_oe(oe_b), .sda_i(sda_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural slave ----------------
  logic [7:0]  slv_mem [256];
  logic [7:0]  ref_mem [256];
  logic        inj_nack_addr = 1'b0;
  logic        inj_nack_data = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        s_active = 1'b0;
  logic        s_stop = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_rw = 1'b0;
  logic        s_addr_ok = 1'b0;
  logic [7:0]  s_addr = 8'h00;
  logic [31:0] s_vec = 32'h0;
  int          s_rises = 0;

  initial s_pull = 1'b0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      s_pull   = 1'b0;
      s_active = 1'b0;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
    end else begin
      if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
        s_active = 1'b1;
        s_stop   = 1'b0;
        s_vec    = 32'h0;
        s_rises  = 0;
        s_pull   = 1'b0;
      end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
        if (s_active) s_stop = 1'b1;
        s_active = 1'b0;
      end else if (!prev_scl && scl_bus && s_active) begin
        s_vec   = {s_vec[30:0], sda_bus};
        s_rises = s_rises + 1;
      end else if (prev_scl && !scl_bus && s_active) begin
        // SCL just fell: drive for the bit whose index is s_rises
        s_pull = 1'b0;
        if (s_rises == 9) begin
          s_sel  = (s_vec[8:1] == SLV_ID);
          s_rw   = s_vec[0];
          s_pull = s_sel;
        end else if (s_rises == 18) begin
          s_addr    = s_vec[7:0];
          s_addr_ok = s_sel && !inj_nack_addr;
          s_pull    = s_addr_ok;
        end else if (s_rises >= 19 && s_rises <= 26 && s_rw && s_addr_ok) begin
          s_pull = !slv_mem[s_addr][26 - s_rises];
        end else if (s_rises == 27 && !s_rw && s_addr_ok) begin
          s_pull = !inj_nack_data;
          if (s_pull) slv_mem[s_addr] = s_vec[7:0];
        end
      end
      prev_scl = scl_bus;
      prev_sda = sda_bus;
    end
  end

  // ---------------- checking ----------------
  logic       rd_valid = 1'b0;
  logic [7:0] last_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called #1 after a posedge with the selected master idle
  task automatic issue(input logic rd, input logic [7:0] id, input logic [7:0] addr,
                       input logic [7:0] wd, input logic keep);
    cmd_read     = rd;
    cmd_slave_id = id;
    cmd_addr     = addr;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
    rd_valid = 1'b0;
    check("busy_after_accept", 32'(o_busy), 32'd1);
    check("error_cleared", 32'(o_error), 32'd0);
  endtask

  // called #1 after the accept edge
  task automatic wait_done(input logic rd, input logic [7:0] id, input logic [7:0] addr,
                           input logic [7:0] wd);
    logic [31:0] ev;
    logic [7:0]  byte_v;
    logic        sel_ok, err;
    int          n, t, lat, cnt;
    t      = fast ? 4 : 16;
    sel_ok = (id == SLV_ID);
    ev     = 32'h0;
    n      = 0;
    byte_v = 8'h00;
    for (int i = 7; i >= 0; i--) begin ev = {ev[30:0], id[i]}; n++; end
    ev = {ev[30:0], rd};      n++;
    ev = {ev[30:0], !sel_ok}; n++;
    err = !sel_ok;
    if (sel_ok) begin
      for (int i = 7; i >= 0; i--) begin ev = {ev[30:0], addr[i]}; n++; end
      ev = {ev[30:0], inj_nack_addr}; n++;
      err = inj_nack_addr;
      if (!inj_nack_addr) begin
        byte_v = rd ? ref_mem[addr] : wd;
        for (int i = 7; i >= 0; i--) begin ev = {ev[30:0], byte_v[i]}; n++; end
        ev = {ev[30:0], rd ? 1'b1 : inj_nack_data}; n++;
        err = !rd && inj_nack_data;
        if (!rd && !inj_nack_data) ref_mem[addr] = wd;
      end
    end
    // every bit on the bus plus START and STOP, then one clk for done
    lat = (n + 2) * t + 1;
    cnt = 0;
    while (cnt < 40 * t) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 2) check("busy_mid", 32'(o_busy), 32'd1);
      if (o_done) break;
    end
    check("done_latency", cnt, lat);
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("error", 32'(o_error), 32'(err));
    if (rd && !err) begin
      check("rdata", 32'(o_rdata), 32'(byte_v));
      rd_valid   = 1'b1;
      last_rdata = byte_v;
    end
    check("sda_stream", s_vec >> 1, ev);
    check("scl_rises", s_rises, n + 1);
    check("stop_seen", 32'(s_stop), 32'd1);
  endtask

  task automatic gap(input int cycles);
    @(posedge clk); #1;
    check("done_pulse_width", 32'(o_done), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    check("idle_scl", 32'(o_scl), 32'd1);
    if (rd_valid) check("rdata_hold", 32'(o_rdata), 32'(last_rdata));
  endtask

  initial begin
    logic       rd;
    logic [7:0] id, addr, wd;
    logic       seen;

    reset = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; fast = 1'b0;
    cmd_slave_id = 8'h00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_error", 32'(error_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    check("rst_scl", 32'(scl_a), 32'd1);
    check("rst_sda_oe", 32'(oe_a), 32'd0);
    check("rst_scl_fast", 32'(scl_b), 32'd1);
    check("rst_sda_oe_fast", 32'(oe_b), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // write, all acked
    issue(1'b0, 8'h5A, 8'h10, 8'hC3, 1'b0);
    wait_done(1'b0, 8'h5A, 8'h10, 8'hC3);
    gap(3);

    // read of a known byte
    slv_mem[8'h22] = 8'h9E;
    ref_mem[8'h22] = 8'h9E;
    issue(1'b1, 8'h5A, 8'h22, 8'h00, 1'b0);
    wait_done(1'b1, 8'h5A, 8'h22, 8'h00);
    gap(5);

    // nobody answers id 8'h33
    issue(1'b0, 8'h33, 8'h44, 8'h55, 1'b0);
    wait_done(1'b0, 8'h33, 8'h44, 8'h55);
    gap(3);

    // cmd_valid held through busy with different fields
    issue(1'b0, 8'h5A, 8'h31, 8'hA5, 1'b1);
    cmd_read = 1'b1; cmd_slave_id = 8'h5A; cmd_addr = 8'h10; cmd_wdata = 8'h0F;
    wait_done(1'b0, 8'h5A, 8'h31, 8'hA5);
    @(posedge clk); #1;
    check("reaccept_done_low", 32'(o_done), 32'd0);
    check("reaccept_busy", 32'(o_busy), 32'd1);
    check("reaccept_error", 32'(o_error), 32'd0);
    cmd_valid = 1'b0;
    wait_done(1'b1, 8'h5A, 8'h10, 8'h0F);
    gap(4);

    // reset in MEM_ADDR bit 3 (bus bit 14 counting START as 0)
    issue(1'b0, 8'h5A, 8'hF0, 8'h77, 1'b0);
    repeat (14 * 16 + 6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_scl", 32'(o_scl), 32'd1);
    check("midrst_sda_oe", 32'(o_oe), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    rd_valid = 1'b0;
    seen = 1'b0;
    repeat (40 * 16) begin
      @(posedge clk); #1;
      if (o_done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    issue(1'b1, 8'h5A, 8'h22, 8'h00, 1'b0);
    wait_done(1'b1, 8'h5A, 8'h22, 8'h00);
    gap(2);

    // CLK_DIV = 1 master
    fast = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 8'h5A, 8'h00, 8'hFF, 1'b0);
    wait_done(1'b0, 8'h5A, 8'h00, 8'hFF);
    gap(2);
    issue(1'b1, 8'h5A, 8'h00, 8'h00, 1'b0);
    wait_done(1'b1, 8'h5A, 8'h00, 8'h00);
    gap(2);

    // randomized traffic on both masters
    for (int k = 0; k < 24; k++) begin
      fast = (k >= 16);
      @(posedge clk); #1;
      rd   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 15));
      wd   = 8'($urandom);
      id   = SLV_ID;
      if ($urandom_range(0, 5) == 0) begin
        id = 8'($urandom);
        if (id == SLV_ID) id = 8'h33;
      end
      inj_nack_addr = ($urandom_range(0, 7) == 0);
      inj_nack_data = ($urandom_range(0, 7) == 0);
      issue(rd, id, addr, wd, 1'b0);
      wait_done(rd, id, addr, wd);
      gap($urandom_range(0, 5));
    end
    inj_nack_addr = 1'b0;
    inj_nack_data = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
